// File: rtl/pxor_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined XOR reduction tree.
package pxor_pkg;

  localparam int PXOR_RADIX = 4;

  // Number of radix-4 levels needed to reduce n words to one (at least one level).
  function automatic int pxor_clog4(input int n);
    int stages = 0;
    int span   = 1;
    for (int i = 0; i < 16; i++) begin
      if (span < n) begin
        span   = span * PXOR_RADIX;
        stages = stages + 1;
      end
    end
    return (stages < 1) ? 1 : stages;
  endfunction

  // Input word count after zero-padding to a full radix-4 tree.
  function automatic int pxor_pad(input int n);
    int span = 1;
    for (int i = 0; i < pxor_clog4(n); i++) begin
      span = span * PXOR_RADIX;
    end
    return span;
  endfunction

endpackage

// File: rtl/pxor_stage.sv
// One registered radix-4 XOR level: GROUPS output words, each the XOR of four input words,
// with a valid and a last bit travelling alongside the data.
module pxor_stage
  import pxor_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int GROUPS = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clk_ena,
  input  logic                                 clr,
  input  logic                                 in_valid,
  input  logic                                 in_last,
  input  logic [GROUPS*PXOR_RADIX*WIDTH-1:0]   in_data,
  output logic [GROUPS*WIDTH-1:0]              out_data,
  output logic                                 out_valid,
  output logic                                 out_last
);

  logic [GROUPS*WIDTH-1:0] reduced;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    reduced = '0;
    for (int g = 0; g < GROUPS; g++) begin
      for (int r = 0; r < PXOR_RADIX; r++) begin
        reduced[g*WIDTH +: WIDTH] ^= in_data[(g*PXOR_RADIX + r)*WIDTH +: WIDTH];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every level samples the previous level's old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (clr) begin
      // Flush drops the control bits only; the data word is don't-care once invalid.
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (clk_ena) begin
      out_data  <= reduced;
      out_valid <= in_valid;
      out_last  <= in_valid & in_last;
    end
  end

endmodule

// File: rtl/pxor_tree.sv
// Pipelined NUM_IN-input XOR reduction tree with valid/last tracking.
// Optional frame accumulator enabled by defining PXOR_TREE_ACCUM_EN.
module pxor_tree
  import pxor_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_ena,
  input  logic                    clr,
  input  logic                    in_valid,
  input  logic                    in_last,
  input  logic [NUM_IN*WIDTH-1:0] pbus_in,
  output logic                    out_valid,
  output logic                    out_last,
  output logic [WIDTH-1:0]        busout,
  output logic                    acc_busy
);

  localparam int STAGES = pxor_clog4(NUM_IN);
  localparam int PAD    = pxor_pad(NUM_IN);

  logic [PAD*WIDTH-1:0] pad_bus;

  always_comb begin
    pad_bus = '0;
    pad_bus[NUM_IN*WIDTH-1:0] = pbus_in;
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_lvl
    localparam int GROUPS = PAD / (PXOR_RADIX ** (s + 1));
    logic [GROUPS*WIDTH-1:0] data;
    logic                    valid;
    logic                    last;

    if (s == 0) begin : g_first
      pxor_stage #(.WIDTH(WIDTH), .GROUPS(GROUPS)) u_stage (
        .clk       (clk),
        .rst       (rst),
        .clk_ena   (clk_ena),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data   (pad_bus),
        .out_data  (data),
        .out_valid (valid),
        .out_last  (last)
      );
    end else begin : g_next
      pxor_stage #(.WIDTH(WIDTH), .GROUPS(GROUPS)) u_stage (
        .clk       (clk),
        .rst       (rst),
        .clk_ena   (clk_ena),
        .clr       (clr),
        .in_valid  (g_lvl[s-1].valid),
        .in_last   (g_lvl[s-1].last),
        .in_data   (g_lvl[s-1].data),
        .out_data  (data),
        .out_valid (valid),
        .out_last  (last)
      );
    end
  end

  logic [WIDTH-1:0] tree;
  logic             tree_valid;
  logic             tree_last;

  assign tree       = g_lvl[STAGES-1].data;
  assign tree_valid = g_lvl[STAGES-1].valid;
  assign tree_last  = g_lvl[STAGES-1].last;

`ifdef PXOR_TREE_ACCUM_EN
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      acc       <= '0;
      busout    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (clr) begin
      state     <= ST_IDLE;
      acc       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (clk_ena) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      if (tree_valid) begin
        case (state)
          ST_IDLE: begin
            if (tree_last) begin
              busout    <= tree;
              out_valid <= 1'b1;
              out_last  <= 1'b1;
            end else begin
              acc   <= tree;
              state <= ST_ACCUM;
            end
          end
          default: begin
            if (tree_last) begin
              busout    <= acc ^ tree;
              out_valid <= 1'b1;
              out_last  <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              acc <= acc ^ tree;
            end
          end
        endcase
      end
    end
  end

  assign acc_busy = (state == ST_ACCUM);
`else
  assign busout    = tree;
  assign out_valid = tree_valid;
  assign out_last  = tree_last;
  assign acc_busy  = 1'b0;
`endif

endmodule
